// File: rtl/prio_cap_pkg.sv
// Shared types and helpers for the priority-encoder capture block.
//   CODE_W   width of the encoder code / channel number
//   state_e  capture FSM states
//   chan_of  converts the encoder's inverted code to a true channel number
package prio_cap_pkg;

    localparam int CODE_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        DEB,
        PUSH,
        REL
    } state_e;

    // The encoder drives its code inverted, so channel 5 appears as 3'b010.
    function automatic logic [CODE_W-1:0] chan_of(input logic [CODE_W-1:0] code);
        return ~code;
    endfunction

endpackage

// File: rtl/prio_sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
//   clk, rst_n   clock, asynchronous active-low reset
//   push         write wr_data; accepted when not full or when popping
//   pop          remove the head entry; ignored when empty
//   wr_data      entry to write
//   rd_data      head entry (0 while empty)
//   full, empty  occupancy flags
//   count        number of stored entries, 0..DEPTH
module prio_sync_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign count = count_q;

    // A push into a full FIFO is still accepted when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head is forced to zero while empty so the output has a defined reset value
    // even though the storage itself is not reset.
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; empty/count gate it, and a resettable array costs a reset net per bit.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/prio_code_capture.sv
// Consumer of an 8-to-3 active-low priority encoder.
// Synchronises and debounces the encoder outputs, converts the inverted code to a
// channel number and queues one entry per debounced press.
//   clk, rst_n   clock, asynchronous active-low reset
//   enable       1 = capture active
//   enc_ei_n     encoder enable (registered ~enable)
//   enc_code     encoder code, inverted, asynchronous
//   enc_gs_n     encoder group-select, 0 = some input asserted
//   enc_eo       encoder enable-out, status only
//   code_valid   queue not empty
//   code_ready   host accepts code_data while code_valid=1
//   code_data    channel number at queue head (fall-through)
//   overflow     sticky: a press was dropped on a full queue
//   clr_ovf      one-cycle pulse clearing overflow
//   busy         FSM not idle
module prio_code_capture
    import prio_cap_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic              enc_ei_n,
    input  logic [CODE_W-1:0] enc_code,
    input  logic              enc_gs_n,
    input  logic              enc_eo,
    output logic              code_valid,
    input  logic              code_ready,
    output logic [CODE_W-1:0] code_data,
    output logic              overflow,
    input  logic              clr_ovf,
    output logic              busy
);

    localparam int SYNC_W = CODE_W + 2;
    localparam int CNT_W  = $clog2(DEB_CYCLES + 1);

    // ---------------- Synchronisers: {eo, gs_n, code} per stage ----------------
    logic [SYNC_W-1:0] sync_q [SYNC_STAGES];
    logic [SYNC_W-1:0] sync_d [SYNC_STAGES];
    logic [CODE_W-1:0] s_code;
    logic              s_gs_n;
    logic              s_eo;

    always_comb begin
        sync_d[0] = {enc_eo, enc_gs_n, enc_code};
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    end

    // Reset to all ones: the value an idle encoder presents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign s_code = sync_q[SYNC_STAGES-1][CODE_W-1:0];
    assign s_gs_n = sync_q[SYNC_STAGES-1][CODE_W];
    assign s_eo   = sync_q[SYNC_STAGES-1][CODE_W+1];

    // ---------------- Encoder enable ----------------
    logic enc_ei_n_q, enc_ei_n_d;
    assign enc_ei_n_d = ~enable;
    assign enc_ei_n   = enc_ei_n_q;

    // ---------------- Capture FSM ----------------
    state_e            state_q, state_d;
    logic [CODE_W-1:0] samp_q, samp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cnt_inc;
    logic              push_req;

    assign cnt_inc = cnt_q + CNT_W'(1);

    // s_eo=0 with s_gs_n=0 is illegal from the encoder; only s_gs_n is decoded,
    // which treats that combination as a press.
    always_comb begin
        state_d  = state_q;
        samp_d   = samp_q;
        cnt_d    = cnt_q;
        push_req = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!s_gs_n) begin
                        samp_d = s_code;
                        cnt_d  = CNT_W'(1);
                        // The first pressed sample already counts as one stable cycle.
                        if (DEB_CYCLES == 1) state_d = PUSH;
                        else                 state_d = DEB;
                    end
                end
                DEB: begin
                    if (s_gs_n) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (s_code != samp_q) begin
                        samp_d = s_code;
                        cnt_d  = CNT_W'(1);
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_W'(DEB_CYCLES)) state_d = PUSH;
                    end
                end
                PUSH: begin
                    push_req = 1'b1;
                    cnt_d    = '0;
                    state_d  = REL;
                end
                REL: begin
                    // Any press while held (even a higher-priority one) only restarts the release count.
                    if (!s_gs_n) begin
                        cnt_d = '0;
                    end else if (cnt_inc == CNT_W'(DEB_CYCLES)) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign busy = (state_q != IDLE);

    // ---------------- Code queue ----------------
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        fifo_pop;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    assign fifo_pop   = code_valid && code_ready;
    assign code_valid = !fifo_empty;

    prio_sync_fifo #(
        .WIDTH (CODE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push_req),
        .pop     (fifo_pop),
        .wr_data (chan_of(samp_q)),
        .rd_data (code_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // ---------------- Overflow flag (set beats clear) ----------------
    logic overflow_q, overflow_d;

    always_comb begin
        overflow_d = overflow_q;
        if (push_req && fifo_full && !fifo_pop) overflow_d = 1'b1;
        else if (clr_ovf)                       overflow_d = 1'b0;
    end

    assign overflow = overflow_q;

    // Synchronised eo and the occupancy count are status-only and not decoded here.
    logic unused_status;
    assign unused_status = ^{s_eo, fifo_count};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            samp_q     <= '0;
            cnt_q      <= '0;
            enc_ei_n_q <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            samp_q     <= samp_d;
            cnt_q      <= cnt_d;
            enc_ei_n_q <= enc_ei_n_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_prio_code_capture.sv
module tb_prio_code_capture;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       enc_ei_n;
    logic [2:0] enc_code;
    logic       enc_gs_n;
    logic       enc_eo;
    logic       code_valid;
    logic       code_ready;
    logic [2:0] code_data;
    logic       overflow;
    logic       clr_ovf;
    logic       busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    prio_code_capture dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .enc_ei_n   (enc_ei_n),
        .enc_code   (enc_code),
        .enc_gs_n   (enc_gs_n),
        .enc_eo     (enc_eo),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .code_data  (code_data),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [2:0] chan);
        enc_gs_n = 1'b0;
        enc_code = ~chan;
        enc_eo   = 1'b1;
    endtask

    task automatic release_enc();
        enc_gs_n = 1'b1;
        enc_code = 3'b111;
        enc_eo   = 1'b1;
    endtask

    // Push lands on edge 7 of the press; release is debounced by edge 6.
    task automatic press_release(input logic [2:0] chan);
        press(chan);
        step(8);
        release_enc();
        step(7);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; code_ready = 1'b0; clr_ovf = 1'b0;
        release_enc();
        step(3);
        total_cnt++;
        if ({enc_ei_n, code_valid, code_data, overflow, busy} !== 7'b1_0_000_0_0) begin
            $display("FAIL reset_values: got ei_n=%b valid=%b data=%0d ovf=%b busy=%b, want 1 0 0 0 0",
                     enc_ei_n, code_valid, code_data, overflow, busy);
        end else pass_cnt++;
        rst_n = 1'b1;
        step(2);
    endtask

    task automatic test_latency();
        enable = 1'b1;
        press(3'd5);
        step(1);
        total_cnt++;
        if (enc_ei_n !== 1'b0) $display("FAIL ei_n_follows_enable: got %b want 0", enc_ei_n);
        else pass_cnt++;
        step(5);
        total_cnt++;
        if (code_valid !== 1'b0) $display("FAIL latency_edge6: code_valid=%b want 0", code_valid);
        else pass_cnt++;
        step(1);
        total_cnt++;
        if ({code_valid, code_data} !== {1'b1, 3'd5})
            $display("FAIL latency_edge7: valid=%b data=%0d want 1 5", code_valid, code_data);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL busy_while_held: got %b want 1", busy);
        else pass_cnt++;
        release_enc();
        step(5);
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL busy_release_edge5: got %b want 1", busy);
        else pass_cnt++;
        step(1);
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL busy_release_edge6: got %b want 0", busy);
        else pass_cnt++;
        code_ready = 1'b1;
        step(1);
        code_ready = 1'b0;
        total_cnt++;
        if ({code_valid, code_data} !== 4'b0_000)
            $display("FAIL pop_single: valid=%b data=%0d want 0 0", code_valid, code_data);
        else pass_cnt++;
    endtask

    task automatic test_bounce();
        logic early;
        early = 1'b0;
        // Code alternates chan 5 / chan 4 every 2 cycles, ending on chan 5.
        for (int i = 0; i < 5; i++) begin
            press((i % 2 == 0) ? 3'd5 : 3'd4);
            step(2);
            if (code_valid) early = 1'b1;
        end
        press(3'd5);
        step(4);
        if (code_valid) early = 1'b1;
        total_cnt++;
        if (early !== 1'b0) $display("FAIL bounce_no_early_push: early=%b want 0", early);
        else pass_cnt++;
        step(1);
        total_cnt++;
        if ({code_valid, code_data} !== {1'b1, 3'd5})
            $display("FAIL bounce_push: valid=%b data=%0d want 1 5", code_valid, code_data);
        else pass_cnt++;
        release_enc();
        step(7);
        code_ready = 1'b1;
        step(1);
        code_ready = 1'b0;
        total_cnt++;
        if (code_valid !== 1'b0) $display("FAIL bounce_single_entry: valid=%b want 0", code_valid);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        for (int c = 0; c < 4; c++) press_release(3'(c));
        total_cnt++;
        if (overflow !== 1'b0) $display("FAIL ovf_after_4: got %b want 0", overflow);
        else pass_cnt++;
        press_release(3'd4);
        total_cnt++;
        if (overflow !== 1'b1) $display("FAIL ovf_after_5: got %b want 1", overflow);
        else pass_cnt++;
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        total_cnt++;
        if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b want 0", overflow);
        else pass_cnt++;
        code_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            total_cnt++;
            if ({code_valid, code_data} !== {1'b1, 3'(c)})
                $display("FAIL ovf_pop_%0d: valid=%b data=%0d want 1 %0d", c, code_valid, code_data, c);
            else pass_cnt++;
            step(1);
        end
        code_ready = 1'b0;
        total_cnt++;
        if (code_valid !== 1'b0) $display("FAIL ovf_drained: valid=%b want 0", code_valid);
        else pass_cnt++;
    endtask

    task automatic test_full_push_pop();
        logic [2:0] exp_q [4];
        exp_q = '{3'd5, 3'd4, 3'd3, 3'd7};
        press_release(3'd6);
        press_release(3'd5);
        press_release(3'd4);
        press_release(3'd3);
        press(3'd7);
        step(6);
        total_cnt++;
        if ({code_valid, code_data} !== {1'b1, 3'd6})
            $display("FAIL full_head_before: valid=%b data=%0d want 1 6", code_valid, code_data);
        else pass_cnt++;
        code_ready = 1'b1;
        step(1);
        code_ready = 1'b0;
        total_cnt++;
        if (overflow !== 1'b0) $display("FAIL full_simul_no_ovf: got %b want 0", overflow);
        else pass_cnt++;
        release_enc();
        step(7);
        code_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if ({code_valid, code_data} !== {1'b1, exp_q[i]})
                $display("FAIL full_pop_%0d: valid=%b data=%0d want 1 %0d", i, code_valid, code_data, exp_q[i]);
            else pass_cnt++;
            step(1);
        end
        code_ready = 1'b0;
        total_cnt++;
        if (code_valid !== 1'b0) $display("FAIL full_count4: valid=%b want 0", code_valid);
        else pass_cnt++;
    endtask

    task automatic test_disable();
        press_release(3'd2);
        press(3'd6);
        step(4);
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL dis_busy_in_deb: got %b want 1", busy);
        else pass_cnt++;
        enable = 1'b0;
        step(1);
        total_cnt++;
        if ({busy, enc_ei_n} !== 2'b01)
            $display("FAIL dis_idle: busy=%b ei_n=%b want 0 1", busy, enc_ei_n);
        else pass_cnt++;
        step(8);
        total_cnt++;
        if ({code_valid, code_data, busy} !== {1'b1, 3'd2, 1'b0})
            $display("FAIL dis_nothing_queued: valid=%b data=%0d busy=%b want 1 2 0", code_valid, code_data, busy);
        else pass_cnt++;
        code_ready = 1'b1;
        step(1);
        code_ready = 1'b0;
        total_cnt++;
        if (code_valid !== 1'b0) $display("FAIL dis_drain: valid=%b want 0", code_valid);
        else pass_cnt++;
        release_enc();
        enable = 1'b1;
        step(4);
    endtask

    task automatic test_async_reset();
        press_release(3'd1);
        press(3'd2);
        step(10);
        total_cnt++;
        if ({code_valid, busy} !== 2'b11)
            $display("FAIL arst_pre: valid=%b busy=%b want 1 1", code_valid, busy);
        else pass_cnt++;
        #3 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({enc_ei_n, code_valid, code_data, overflow, busy} !== 7'b1_0_000_0_0)
            $display("FAIL arst_immediate: ei_n=%b valid=%b data=%0d ovf=%b busy=%b want 1 0 0 0 0",
                     enc_ei_n, code_valid, code_data, overflow, busy);
        else pass_cnt++;
        release_enc();
        step(2);
        rst_n = 1'b1;
        step(4);
        total_cnt++;
        if ({code_valid, busy} !== 2'b00)
            $display("FAIL arst_after: valid=%b busy=%b want 0 0", code_valid, busy);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_bounce();
        test_overflow();
        test_full_push_pop();
        test_disable();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
